// File: rtl/multi_channel_sampler.sv
// N-channel comparator sampler: 2-bit {H,L} pairs packed DEPTH per word; word on smpl one clk after the completing strobe.
// smpl/smpl_vld hold until accepted; a word completing while the held one is still refused is dropped and sets sticky ovr.
module multi_channel_sampler #(
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 4,
  parameter int SYNC   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       smpl_en,
  input  logic                       clr_cnt,
  input  logic [NUM_CH-1:0]          CH_H,
  input  logic [NUM_CH-1:0]          CH_L,
  input  logic                       smpl_rdy,
  output logic [NUM_CH*2*DEPTH-1:0]  smpl,
  output logic                       smpl_vld,
  output logic [NUM_CH-1:0]          CH_Hrise,
  output logic [NUM_CH-1:0]          CH_Lfall,
  output logic                       ovr
);

  localparam int W  = 2 * DEPTH;
  localparam int CW = $clog2(DEPTH);

  logic [NUM_CH-1:0]     h_sync [SYNC];
  logic [NUM_CH-1:0]     l_sync [SYNC];
  logic [NUM_CH-1:0]     hs, ls;
  logic [NUM_CH-1:0]     prev_h, prev_l;
  logic                  first;
  logic [CW-1:0]         count;
  // Only the DEPTH-1 older pairs are stored; the newest pair comes straight from the synchroniser.
  logic [W-3:0]          sr     [NUM_CH];
  logic [W-1:0]          sr_full[NUM_CH];
  logic [NUM_CH*W-1:0]   word_nxt;
  logic                  sample, last, complete, accept;

  assign hs = h_sync[SYNC-1];
  assign ls = l_sync[SYNC-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) begin
        h_sync[k] <= '0;
        l_sync[k] <= '0;
      end
    end else begin
      h_sync[0] <= CH_H;
      l_sync[0] <= CH_L;
      for (int k = 1; k < SYNC; k++) begin
        h_sync[k] <= h_sync[k-1];
        l_sync[k] <= l_sync[k-1];
      end
    end
  end

  always_comb begin
    word_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sr_full[i] = {sr[i], hs[i], ls[i]};
      word_nxt[i*W +: W] = sr_full[i];
    end
  end

  assign sample   = smpl_en & ~clr_cnt;
  assign last     = (count == CW'(DEPTH - 1));
  assign complete = sample & last;
  assign accept   = smpl_vld & smpl_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      first  <= 1'b1;
      prev_h <= '0;
      prev_l <= '0;
      for (int i = 0; i < NUM_CH; i++) sr[i] <= '0;
    end else if (clr_cnt) begin
      count <= '0;
      first <= 1'b1;
    end else if (smpl_en) begin
      count  <= last ? '0 : count + 1'b1;
      first  <= 1'b0;
      prev_h <= hs;
      prev_l <= ls;
      for (int i = 0; i < NUM_CH; i++) sr[i] <= sr_full[i][W-3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl     <= '0;
      smpl_vld <= 1'b0;
      ovr      <= 1'b0;
      CH_Hrise <= '0;
      CH_Lfall <= '0;
    end else begin
      CH_Hrise <= (sample && !first) ? (hs & ~prev_h) : '0;
      CH_Lfall <= (sample && !first) ? (~ls & prev_l) : '0;
      if (complete && (!smpl_vld || smpl_rdy)) begin
        smpl     <= word_nxt;
        smpl_vld <= 1'b1;
      end else if (accept) begin
        smpl_vld <= 1'b0;
      end
      if (complete && smpl_vld && !smpl_rdy) ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_channel_sampler.sv
// Bench for multi_channel_sampler: directed scenarios with literal checks plus random traffic,
// all outputs compared every cycle against a queue-based model of the sampling rules.
module tb_multi_channel_sampler;
  localparam int NUM_CH = 5;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;
  localparam int W      = 2 * DEPTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 smpl_en = 1'b0;
  logic                 clr_cnt = 1'b0;
  logic                 smpl_rdy = 1'b0;
  logic [NUM_CH-1:0]    CH_H = '0;
  logic [NUM_CH-1:0]    CH_L = '0;
  logic [NUM_CH*W-1:0]  smpl;
  logic                 smpl_vld;
  logic [NUM_CH-1:0]    CH_Hrise;
  logic [NUM_CH-1:0]    CH_Lfall;
  logic                 ovr;

  int n_tests = 0;
  int n_fail  = 0;

  multi_channel_sampler #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .smpl_en(smpl_en), .clr_cnt(clr_cnt),
    .CH_H(CH_H), .CH_L(CH_L), .smpl_rdy(smpl_rdy), .smpl(smpl),
    .smpl_vld(smpl_vld), .CH_Hrise(CH_Hrise), .CH_Lfall(CH_Lfall), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input delay line, list of samples gathered for the current word, handshake state.
  logic [NUM_CH-1:0]   dl_h[$], dl_l[$];
  logic [NUM_CH-1:0]   sh[$], sl[$];
  logic [NUM_CH-1:0]   m_ph, m_pl, m_hrise, m_lfall;
  logic [NUM_CH*W-1:0] m_smpl;
  logic                m_vld, m_ovr, m_first;

  task automatic model_reset();
    dl_h.delete(); dl_l.delete(); sh.delete(); sl.delete();
    for (int k = 0; k < SYNC; k++) begin
      dl_h.push_back('0);
      dl_l.push_back('0);
    end
    m_ph = '0; m_pl = '0; m_hrise = '0; m_lfall = '0;
    m_smpl = '0; m_vld = 1'b0; m_ovr = 1'b0; m_first = 1'b1;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0]   h, l;
    logic [NUM_CH*W-1:0] w;
    logic                accepted, done;
    int                  v;
    h = dl_h.pop_front();
    l = dl_l.pop_front();
    dl_h.push_back(CH_H);
    dl_l.push_back(CH_L);
    accepted = m_vld && smpl_rdy;
    done = 1'b0;
    m_hrise = '0;
    m_lfall = '0;
    if (clr_cnt) begin
      sh.delete(); sl.delete();
      m_first = 1'b1;
    end else if (smpl_en) begin
      if (!m_first) begin
        m_hrise = h & ~m_ph;
        m_lfall = ~l & m_pl;
      end
      m_ph = h; m_pl = l; m_first = 1'b0;
      sh.push_back(h);
      sl.push_back(l);
      if (sh.size() == DEPTH) begin
        done = 1'b1;
        w = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          v = 0;
          for (int k = 0; k < DEPTH; k++) v = v * 4 + 2 * int'(sh[k][c]) + int'(sl[k][c]);
          w[c*W +: W] = W'(v);
        end
        sh.delete(); sl.delete();
        if (!m_vld || smpl_rdy) begin
          m_smpl = w;
          m_vld  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (!done && accepted) m_vld = 1'b0;
  endtask

  task automatic compare();
    chk("smpl", 64'(smpl), 64'(m_smpl));
    chk("smpl_vld", 64'(smpl_vld), 64'(m_vld));
    chk("CH_Hrise", 64'(CH_Hrise), 64'(m_hrise));
    chk("CH_Lfall", 64'(CH_Lfall), 64'(m_lfall));
    chk("ovr", 64'(ovr), 64'(m_ovr));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1 compare();
    end
  end

  task automatic strobe(input logic [NUM_CH-1:0] h, input logic [NUM_CH-1:0] l,
                        input logic clr = 1'b0);
    CH_H = h;
    CH_L = l;
    repeat (SYNC) @(negedge clk);
    smpl_en = 1'b1;
    clr_cnt = clr;
    @(negedge clk);
    smpl_en = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nw;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw;
    smpl_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_vld", 64'(smpl_vld), 64'd0);
    chk("reset_smpl", 64'(smpl), 64'd0);
    rst_n = 1'b1;

    // Channel 0 pairs 11,10,01,00 -> 8'hE4
    strobe(5'b00001, 5'b00001);
    strobe(5'b00001, 5'b00000);
    strobe(5'b00000, 5'b00001);
    strobe(5'b00000, 5'b00000);
    chk("t1_vld", 64'(smpl_vld), 64'd1);
    chk("t1_word", 64'(smpl[7:0]), 64'hE4);
    chk("t1_model", 64'(m_smpl[7:0]), 64'hE4);
    @(negedge clk);
    chk("t1_vld_drop", 64'(smpl_vld), 64'd0);

    // Backpressure across two words: first held, second dropped
    do_reset();
    smpl_rdy = 1'b0;
    strobe(5'b00000, 5'b00001);
    strobe(5'b00001, 5'b00000);
    strobe(5'b00001, 5'b00001);
    strobe(5'b00000, 5'b00000);
    chk("t2_vld", 64'(smpl_vld), 64'd1);
    chk("t2_word", 64'(smpl[7:0]), 64'h6C);
    chk("t2_no_ovr", 64'(ovr), 64'd0);
    repeat (4) strobe(5'b11111, 5'b11111);
    chk("t2_ovr", 64'(ovr), 64'd1);
    chk("t2_held", 64'(smpl[7:0]), 64'h6C);
    smpl_rdy = 1'b1;
    @(negedge clk);
    chk("t2_vld_drop", 64'(smpl_vld), 64'd0);
    chk("t2_ovr_sticky", 64'(ovr), 64'd1);

    // Rising edge on channel index 2; none on the first strobe
    do_reset();
    strobe(5'b00100, 5'b00000);
    chk("t3_first_no_edge", 64'(CH_Hrise), 64'd0);
    repeat (4) strobe(5'b00000, 5'b00000);
    strobe(5'b00100, 5'b00000);
    chk("t3_rise", 64'(CH_Hrise), 64'h04);
    @(negedge clk);
    chk("t3_rise_1cyc", 64'(CH_Hrise), 64'd0);

    // Clear coincident with a strobe
    do_reset();
    strobe(5'b00000, 5'b00000);
    strobe(5'b00000, 5'b00000);
    strobe(5'b11111, 5'b11111, 1'b1);
    strobe(5'b11111, 5'b00000);
    chk("t4_no_edge_after_clr", 64'(CH_Hrise), 64'd0);
    chk("t4_vld_0a", 64'(smpl_vld), 64'd0);
    strobe(5'b00000, 5'b11111);
    chk("t4_vld_0b", 64'(smpl_vld), 64'd0);
    strobe(5'b11111, 5'b11111);
    chk("t4_vld_0c", 64'(smpl_vld), 64'd0);
    strobe(5'b00000, 5'b00000);
    chk("t4_vld", 64'(smpl_vld), 64'd1);
    chk("t4_word", 64'(smpl[7:0]), 64'h9C);

    // Continuous strobe: one word per DEPTH clocks
    do_reset();
    smpl_en = 1'b1;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (smpl_vld) nw++;
      CH_H = NUM_CH'($urandom);
      CH_L = NUM_CH'($urandom);
    end
    smpl_en = 1'b0;
    chk("t5_words", 64'(nw), 64'd5);
    chk("t5_no_ovr", 64'(ovr), 64'd0);

    // Synchroniser latency: input changed with the strobe surfaces SYNC samples later
    do_reset();
    CH_H = '0; CH_L = '0;
    repeat (3) @(negedge clk);
    CH_H = 5'b00001;
    smpl_en = 1'b1;
    @(negedge clk);
    chk("t5_sync_a", 64'(CH_Hrise), 64'd0);
    @(negedge clk);
    chk("t5_sync_b", 64'(CH_Hrise), 64'd0);
    @(negedge clk);
    chk("t5_sync_c", 64'(CH_Hrise), 64'd1);
    smpl_en = 1'b0;

    // Asynchronous reset mid-word and mid-handshake
    do_reset();
    smpl_rdy = 1'b0;
    strobe(NUM_CH'($urandom), NUM_CH'($urandom));
    strobe(NUM_CH'($urandom), NUM_CH'($urandom));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_mid_word_vld", 64'(smpl_vld), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) strobe(5'b11111, 5'b01010);
    chk("t6_vld_before", 64'(smpl_vld), 64'd1);
    strobe(NUM_CH'($urandom), NUM_CH'($urandom));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_vld", 64'(smpl_vld), 64'd0);
    chk("t6_async_smpl", 64'(smpl), 64'd0);
    chk("t6_async_ovr", 64'(ovr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    smpl_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(NUM_CH'($urandom), NUM_CH'($urandom));
      chk("t6_fresh_vld0", 64'(smpl_vld), 64'd0);
    end
    strobe(NUM_CH'($urandom), NUM_CH'($urandom));
    chk("t6_fresh_vld1", 64'(smpl_vld), 64'd1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      smpl_en  = ($urandom_range(0, 2) != 0);
      clr_cnt  = ($urandom_range(0, 19) == 0);
      smpl_rdy = ($urandom_range(0, 3) != 0);
      CH_H     = NUM_CH'($urandom);
      CH_L     = NUM_CH'($urandom);
    end
    @(negedge clk);
    smpl_en = 1'b0;
    clr_cnt = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
